// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction-memory req/ready handshake,
// holds the IF/ID register and redirects on taken branches (no delay slot).
module instruction_fetch_unit #(
    parameter int               NBITS    = 32,
    parameter logic [NBITS-1:0] PC_RESET = 32'h0040_0000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_branch_eq,
    input  logic             i_branch_ne,
    input  logic             i_zero,
    input  logic [15:0]      i_branch_imm,
    output logic             o_imem_req,
    output logic [NBITS-1:0] o_imem_addr,
    input  logic             i_imem_ready,
    input  logic [NBITS-1:0] i_imem_rdata,
    output logic [NBITS-1:0] o_instr,
    output logic [5:0]       o_op,
    output logic [NBITS-1:0] o_pc_plus4,
    output logic             o_instr_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP
    } state_t;

    state_t           r_state;
    logic [NBITS-1:0] r_pc;
    logic [NBITS-1:0] r_instr;
    logic [NBITS-1:0] r_pc_plus4;
    logic [NBITS-1:0] r_hold;
    logic             r_req;
    logic             r_valid;

    logic             w_take;
    logic             w_accept;
    logic [NBITS-1:0] w_pc_seq;
    logic [NBITS-1:0] w_target;
    logic [NBITS-1:0] w_offset;

    assign w_take   = r_valid & ~i_stall &
                      ((i_branch_eq & i_zero) | (i_branch_ne & ~i_zero));
    assign w_accept = ~r_valid | ~i_stall;
    assign w_pc_seq = r_pc + NBITS'(4);
    assign w_offset = {{(NBITS-18){i_branch_imm[15]}}, i_branch_imm, 2'b00};
    assign w_target = r_pc_plus4 + w_offset;

    // The address is the PC register itself, so it cannot move while a request waits.
    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_op          = r_instr[NBITS-1:NBITS-6];
    assign o_pc_plus4    = r_pc_plus4;
    assign o_instr_valid = r_valid;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_pc       <= PC_RESET;
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_hold     <= '0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                S_REQ: begin
                    if (w_take) begin
                        r_pc    <= w_target;
                        r_instr <= '0;
                        r_valid <= 1'b0;
                        if (!i_imem_ready) begin
                            r_state <= S_DROP;
                            r_req   <= 1'b0;
                        end
                    end else if (i_imem_ready) begin
                        if (w_accept) begin
                            r_instr    <= i_imem_rdata;
                            r_pc_plus4 <= w_pc_seq;
                            r_valid    <= 1'b1;
                            r_pc       <= w_pc_seq;
                        end else begin
                            r_hold  <= i_imem_rdata;
                            r_state <= S_HOLD;
                            r_req   <= 1'b0;
                        end
                    end else if (!i_stall) begin
                        r_valid <= 1'b0;
                        r_instr <= '0;
                    end
                end
                S_HOLD: begin
                    if (w_take) begin
                        r_pc    <= w_target;
                        r_instr <= '0;
                        r_valid <= 1'b0;
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end else if (!i_stall) begin
                        r_instr    <= r_hold;
                        r_pc_plus4 <= w_pc_seq;
                        r_valid    <= 1'b1;
                        r_pc       <= w_pc_seq;
                        r_state    <= S_REQ;
                        r_req      <= 1'b1;
                    end
                end
                S_DROP: begin
                    // Response of the abandoned request is swallowed here.
                    if (i_imem_ready) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: per-cycle vector table plus
// hand-written reset / restart / PC-wrap sequences.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall, beq, bne, zero, ready;
    logic [15:0] imm;
    logic [31:0] rdata;

    logic        req,  valid;
    logic [31:0] addr, instr, pc4;
    logic [5:0]  op;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc4;
    logic [5:0]  w_op;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch_unit u_dut (
        .i_clk(clk), .i_reset(rst_n), .i_stall(stall),
        .i_branch_eq(beq), .i_branch_ne(bne), .i_zero(zero), .i_branch_imm(imm),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_ready(ready), .i_imem_rdata(rdata),
        .o_instr(instr), .o_op(op), .o_pc_plus4(pc4), .o_instr_valid(valid)
    );

    instruction_fetch_unit #(.NBITS(32), .PC_RESET(32'hFFFF_FFF8)) u_wrap (
        .i_clk(clk), .i_reset(rst_n), .i_stall(stall),
        .i_branch_eq(beq), .i_branch_ne(bne), .i_zero(zero), .i_branch_imm(imm),
        .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_ready(ready), .i_imem_rdata(rdata),
        .o_instr(w_instr), .o_op(w_op), .o_pc_plus4(w_pc4), .o_instr_valid(w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, beq, bne, zero, ready;
        logic [15:0] imm;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic be, input logic bn, input logic z,
                       input logic [15:0] im, input logic rd, input logic [31:0] dat,
                       input logic er, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.beq = be; v.bne = bn; v.zero = z; v.imm = im;
        v.ready = rd; v.rdata = dat;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        logic [5:0] eop;
        eop = ei[31:26];
        check({tag, ".req"},   {31'b0, req},   {31'b0, er});
        check({tag, ".addr"},  addr,           ea);
        check({tag, ".valid"}, {31'b0, valid}, {31'b0, ev});
        check({tag, ".instr"}, instr,          ei);
        check({tag, ".op"},    {26'b0, op},    {26'b0, eop});
        check({tag, ".pc4"},   pc4,            ep);
    endtask

    task automatic drive(input logic s, input logic be, input logic bn, input logic z,
                         input logic [15:0] im, input logic rd, input logic [31:0] dat);
        stall = s; beq = be; bne = bn; zero = z; imm = im; ready = rd; rdata = dat;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 16'h0, 0, 32'h0);
        #2 rst_n = 1'b0;

        //   stall beq bne zero imm      rdy rdata          req addr          vld instr          pc4
        add(0, 0, 0, 0, 16'h0000, 1, 32'hA0A0_A0A0, 1, 32'h0040_0000, 0, 32'h0000_0000, 32'h0000_0000);
        add(0, 0, 0, 0, 16'h0000, 1, 32'h2008_0005, 1, 32'h0040_0004, 1, 32'h2008_0005, 32'h0040_0004);
        add(0, 0, 0, 0, 16'h0000, 1, 32'h1111_0001, 1, 32'h0040_0008, 1, 32'h1111_0001, 32'h0040_0008);
        add(0, 0, 0, 0, 16'h0000, 1, 32'h2222_0002, 1, 32'h0040_000C, 1, 32'h2222_0002, 32'h0040_000C);
        add(0, 0, 0, 0, 16'h0000, 1, 32'h3333_0003, 1, 32'h0040_0010, 1, 32'h3333_0003, 32'h0040_0010);
        add(1, 0, 0, 0, 16'h0000, 1, 32'h4444_0004, 0, 32'h0040_0010, 1, 32'h3333_0003, 32'h0040_0010);
        add(1, 0, 0, 0, 16'h0000, 0, 32'h0000_0000, 0, 32'h0040_0010, 1, 32'h3333_0003, 32'h0040_0010);
        add(0, 0, 0, 0, 16'h0000, 0, 32'h0000_0000, 1, 32'h0040_0014, 1, 32'h4444_0004, 32'h0040_0014);
        add(0, 0, 0, 0, 16'h0000, 1, 32'h5555_0005, 1, 32'h0040_0018, 1, 32'h5555_0005, 32'h0040_0018);
        add(0, 1, 0, 1, 16'h0003, 1, 32'h6666_0006, 1, 32'h0040_0024, 0, 32'h0000_0000, 32'h0040_0018);
        add(0, 0, 0, 0, 16'h0000, 1, 32'h7777_0007, 1, 32'h0040_0028, 1, 32'h7777_0007, 32'h0040_0028);
        add(0, 0, 1, 1, 16'h0010, 1, 32'h8888_0008, 1, 32'h0040_002C, 1, 32'h8888_0008, 32'h0040_002C);
        add(0, 1, 0, 1, 16'hFFFF, 1, 32'h9999_0009, 1, 32'h0040_0028, 0, 32'h0000_0000, 32'h0040_002C);
        add(0, 0, 0, 0, 16'h0000, 0, 32'h0000_0000, 1, 32'h0040_0028, 0, 32'h0000_0000, 32'h0040_002C);
        add(0, 0, 0, 0, 16'h0000, 1, 32'hAAAA_000A, 1, 32'h0040_002C, 1, 32'hAAAA_000A, 32'h0040_002C);
        add(0, 0, 1, 0, 16'h0004, 0, 32'h0000_0000, 0, 32'h0040_003C, 0, 32'h0000_0000, 32'h0040_002C);
        add(0, 0, 0, 0, 16'h0000, 0, 32'h0000_0000, 0, 32'h0040_003C, 0, 32'h0000_0000, 32'h0040_002C);
        add(0, 0, 0, 0, 16'h0000, 1, 32'hDEAD_BEEF, 1, 32'h0040_003C, 0, 32'h0000_0000, 32'h0040_002C);
        add(0, 0, 0, 0, 16'h0000, 1, 32'hBBBB_000B, 1, 32'h0040_0040, 1, 32'hBBBB_000B, 32'h0040_0040);
        add(1, 1, 0, 1, 16'h0100, 0, 32'h0000_0000, 1, 32'h0040_0040, 1, 32'hBBBB_000B, 32'h0040_0040);
        add(0, 1, 0, 1, 16'h0100, 0, 32'h0000_0000, 0, 32'h0040_0440, 0, 32'h0000_0000, 32'h0040_0040);
        add(0, 0, 0, 0, 16'h0000, 1, 32'hCCCC_CCCC, 1, 32'h0040_0440, 0, 32'h0000_0000, 32'h0040_0040);
        add(0, 0, 0, 0, 16'h0000, 1, 32'hCCCC_000C, 1, 32'h0040_0444, 1, 32'hCCCC_000C, 32'h0040_0444);
        add(1, 0, 0, 0, 16'h0000, 1, 32'hEEEE_000E, 0, 32'h0040_0444, 1, 32'hCCCC_000C, 32'h0040_0444);
        add(0, 1, 0, 1, 16'h0002, 0, 32'h0000_0000, 1, 32'h0040_044C, 0, 32'h0000_0000, 32'h0040_0444);
        add(0, 0, 0, 0, 16'h0000, 1, 32'h1234_5678, 1, 32'h0040_0450, 1, 32'h1234_5678, 32'h0040_0450);
        add(0, 0, 0, 0, 16'h0000, 0, 32'h0000_0000, 1, 32'h0040_0450, 0, 32'h0000_0000, 32'h0040_0450);
        add(0, 0, 0, 0, 16'h0000, 1, 32'h0F0F_0F0F, 1, 32'h0040_0454, 1, 32'h0F0F_0F0F, 32'h0040_0454);
        add(0, 1, 0, 0, 16'h0008, 1, 32'hFC00_0001, 1, 32'h0040_0458, 1, 32'hFC00_0001, 32'h0040_0458);

        #10;
        check_main("reset", 0, 32'h0040_0000, 0, 32'h0, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].beq, vecs[i].bne, vecs[i].zero,
                  vecs[i].imm, vecs[i].ready, vecs[i].rdata);
            @(posedge clk);
            #1;
            check_main($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                       vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc4);
        end

        // Reset while a request is outstanding must clear everything at once.
        drive(0, 0, 0, 0, 16'h0, 0, 32'h0);
        @(posedge clk);
        #1;
        check_main("pre_rst", 1, 32'h0040_0458, 0, 32'h0, 32'h0040_0458);
        #1 rst_n = 1'b0;
        #1;
        check_main("mid_rst", 0, 32'h0040_0000, 0, 32'h0, 32'h0);
        check("wrap_rst.addr", w_addr, 32'hFFFF_FFF8);
        check("wrap_rst.req", {31'b0, w_req}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 16'h0, 1, 32'h2008_0005);
        @(posedge clk);
        #1;
        check_main("rs1", 1, 32'h0040_0000, 0, 32'h0, 32'h0);
        check("wrap1.addr", w_addr, 32'hFFFF_FFF8);
        check("wrap1.req", {31'b0, w_req}, 32'h1);
        @(posedge clk);
        #1;
        check_main("rs2", 1, 32'h0040_0004, 1, 32'h2008_0005, 32'h0040_0004);
        check("wrap2.addr", w_addr, 32'hFFFF_FFFC);
        check("wrap2.pc4", w_pc4, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 16'h0, 1, 32'h0000_0001);
        @(posedge clk);
        #1;
        check_main("rs3", 1, 32'h0040_0008, 1, 32'h0000_0001, 32'h0040_0008);
        check("wrap3.addr", w_addr, 32'h0000_0000);
        check("wrap3.pc4", w_pc4, 32'h0000_0000);
        drive(0, 1, 0, 1, 16'h0003, 1, 32'h0000_0002);
        @(posedge clk);
        #1;
        check_main("beq", 1, 32'h0040_0014, 0, 32'h0, 32'h0040_0008);
        check("wrap_beq.addr", w_addr, 32'h0000_000C);
        drive(0, 0, 0, 0, 16'h0, 1, 32'h0000_0003);
        @(posedge clk);
        #1;
        check_main("beq_tgt", 1, 32'h0040_0018, 1, 32'h0000_0003, 32'h0040_0018);
        check("wrap_tgt.pc4", w_pc4, 32'h0000_0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
